// File: rtl/data_memory.sv
// Processor data memory: 2048-word RAM plus memory-mapped HEX/LED output
// registers and KEY/SW inputs. Reads are combinational; writes land on the clock edge.
module data_memory #(
  parameter int unsigned DBITS        = 32,
  parameter int unsigned DMEMADDRBITS = 13,
  parameter int unsigned DMEMWORDBITS = 2,
  parameter int unsigned DMEMWORDS    = 2048,
  parameter logic [31:0] ADDR_HEX     = 32'hF000_0000,
  parameter logic [31:0] ADDR_LEDR    = 32'hF000_0004,
  parameter logic [31:0] ADDR_LEDG    = 32'hF000_0008,
  parameter logic [31:0] ADDR_KEY     = 32'hF000_0010,
  parameter logic [31:0] ADDR_SW      = 32'hF000_0014
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrEn,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] wrData,
  input  logic [9:0]       SW,
  input  logic [3:0]       KEY,
  output logic [9:0]       LEDR,
  output logic [7:0]       LEDG,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [DBITS-1:0] rdData
);

  localparam int unsigned IDXBITS = DMEMADDRBITS - DMEMWORDBITS;
  localparam logic [6:0]  SEGZERO = 7'b1000000;

  logic [DBITS-1:0]   mem [DMEMWORDS];
  logic [IDXBITS-1:0] wordIdx;
  logic [15:0]        hexReg;
  logic [9:0]         ledrReg;
  logic [7:0]         ledgReg;
  logic               isHex, isLedr, isLedg, isKey, isSw, isRam;
  logic               doWrite;

  // Active-low gfedcba segment encoding of one hex digit
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // Word-granular decode; addr[1:0] never participate
  always_comb begin
    isHex   = (addr[DBITS-1:2] == ADDR_HEX[DBITS-1:2]);
    isLedr  = (addr[DBITS-1:2] == ADDR_LEDR[DBITS-1:2]);
    isLedg  = (addr[DBITS-1:2] == ADDR_LEDG[DBITS-1:2]);
    isKey   = (addr[DBITS-1:2] == ADDR_KEY[DBITS-1:2]);
    isSw    = (addr[DBITS-1:2] == ADDR_SW[DBITS-1:2]);
    isRam   = !(isHex || isLedr || isLedg || isKey || isSw);
    wordIdx = addr[DMEMADDRBITS-1:DMEMWORDBITS];
    doWrite = wrEn && reset;
  end

  // RAM is not reset; it aliases every 2^DMEMADDRBITS bytes
  always_ff @(posedge clk) begin
    if (doWrite && isRam) mem[wordIdx] <= wrData;
  end

  // Segment codes are registered alongside hexReg so HEX outputs come straight from flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hexReg  <= '0;
      ledrReg <= '0;
      ledgReg <= '0;
      HEX0    <= SEGZERO;
      HEX1    <= SEGZERO;
      HEX2    <= SEGZERO;
      HEX3    <= SEGZERO;
    end else if (wrEn) begin
      if (isHex) begin
        hexReg <= wrData[15:0];
        HEX0   <= seg7(wrData[3:0]);
        HEX1   <= seg7(wrData[7:4]);
        HEX2   <= seg7(wrData[11:8]);
        HEX3   <= seg7(wrData[15:12]);
      end
      if (isLedr) ledrReg <= wrData[9:0];
      if (isLedg) ledgReg <= wrData[7:0];
    end
  end

  assign LEDR = ledrReg;
  assign LEDG = ledgReg;

  // Zero-latency load path
  always_comb begin
    rdData = mem[wordIdx];
    if (isHex)  rdData = DBITS'(hexReg);
    if (isLedr) rdData = DBITS'(ledrReg);
    if (isLedg) rdData = DBITS'(ledgReg);
    if (isKey)  rdData = DBITS'(KEY);
    if (isSw)   rdData = DBITS'(SW);
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory: RAM, aliasing, memory-mapped
// I/O readback, seven-segment decode and asynchronous reset.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        wrEn;
  logic [31:0] addr;
  logic [31:0] wrData;
  logic [9:0]  SW;
  logic [3:0]  KEY;
  logic [9:0]  LEDR;
  logic [7:0]  LEDG;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;
  logic [31:0] rdData;

  int checks   = 0;
  int failures = 0;

  data_memory dut (
    .clk(clk), .reset(reset), .wrEn(wrEn), .addr(addr), .wrData(wrData),
    .SW(SW), .KEY(KEY), .LEDR(LEDR), .LEDG(LEDG),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .rdData(rdData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a store between edges, let one rising edge commit it
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wrData = d; wrEn = 1'b1;
    @(posedge clk);
    #1 wrEn = 1'b0;
  endtask

  task automatic load(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1 check(tag, rdData, exp);
  endtask

  initial begin
    reset = 1'b0; wrEn = 1'b0; addr = '0; wrData = '0; SW = '0; KEY = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ledr", 32'(LEDR), 32'h0);
    check("rst_ledg", 32'(LEDG), 32'h0);
    check("rst_hex0", 32'(HEX0), 32'(7'b1000000));
    check("rst_hex3", 32'(HEX3), 32'(7'b1000000));
    @(negedge clk) reset = 1'b1;

    store(32'h400, 32'h37);
    store(32'h404, 32'hE1);
    load("ld_404", 32'h404, 32'hE1);
    load("ld_400", 32'h404 + 32'hFFFF_FFFC, 32'h37);

    // Same-cycle read of the address being written sees the old word
    @(negedge clk);
    addr = 32'h404; wrData = 32'h99; wrEn = 1'b1;
    #1 check("rd_during_wr", rdData, 32'hE1);
    @(posedge clk);
    #1 wrEn = 1'b0;
    check("rd_after_wr", rdData, 32'h99);

    store(32'h2400, 32'hDEADBEEF);
    load("alias_400", 32'h400, 32'hDEADBEEF);
    load("lowbits_402", 32'h402, 32'hDEADBEEF);
    store(32'h400, 32'h37);

    store(32'hF000_0000, 32'h1234);
    #1;
    check("hex0", 32'(HEX0), 32'(7'b0011001));
    check("hex1", 32'(HEX1), 32'(7'b0110000));
    check("hex2", 32'(HEX2), 32'(7'b0100100));
    check("hex3", 32'(HEX3), 32'(7'b1111001));
    load("ld_hex", 32'hF000_0000, 32'h1234);

    store(32'hF000_0004, 32'hFFFF_FFFF);
    store(32'hF000_0008, 32'hFFFF_FFFF);
    #1;
    check("ledr", 32'(LEDR), 32'h3FF);
    check("ledg", 32'(LEDG), 32'hFF);
    load("ld_ledr", 32'hF000_0004, 32'h3FF);
    load("ld_ledg", 32'hF000_0008, 32'hFF);

    // Input ports: readback, and stores to them touch neither port nor RAM alias
    store(32'h14, 32'h11);
    SW = 10'h2A5; KEY = 4'hA;
    load("ld_sw", 32'hF000_0014, 32'h2A5);
    load("ld_key", 32'hF000_0010, 32'hA);
    store(32'hF000_0014, 32'hFFFF_FFFF);
    store(32'hF000_0010, 32'hFFFF_FFFF);
    load("sw_after_st", 32'hF000_0014, 32'h2A5);
    load("key_after_st", 32'hF000_0010, 32'hA);
    load("ram_alias_sw", 32'h14, 32'h11);

    // Asynchronous reset between edges
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_ledr", 32'(LEDR), 32'h0);
    check("arst_ledg", 32'(LEDG), 32'h0);
    check("arst_hex0", 32'(HEX0), 32'(7'b1000000));
    check("arst_hex1", 32'(HEX1), 32'(7'b1000000));
    check("arst_hex2", 32'(HEX2), 32'(7'b1000000));
    check("arst_hex3", 32'(HEX3), 32'(7'b1000000));
    load("arst_ram400", 32'h400, 32'h37);

    // Stores are blocked while reset is held
    store(32'h404, 32'h77);
    store(32'hF000_0000, 32'hABCD);
    load("blk_ram404", 32'h404, 32'h99);
    load("blk_hex", 32'hF000_0000, 32'h0);
    check("blk_hex0", 32'(HEX0), 32'(7'b1000000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Single-cycle processor data memory with memory-mapped board I/O; sits after the Execute stage.
- Address comes from the ALU result; write data comes from the second register-read port; read data feeds the register write-back mux.
- Holds a 2048-word RAM plus output registers for the 7-segment displays, red LEDs and green LEDs, and read ports for the keys and switches.

Parameters:
- DBITS, 32, data and address width
- DMEMADDRBITS, 13, byte-address bits used to index RAM
- DMEMWORDBITS, 2, byte-offset bits dropped for word indexing
- DMEMWORDS, 2048, RAM depth in words
- ADDR_HEX, 32'hF0000000, 7-segment display register
- ADDR_LEDR, 32'hF0000004, red LED register
- ADDR_LEDG, 32'hF0000008, green LED register
- ADDR_KEY, 32'hF0000010, key input (read-only)
- ADDR_SW, 32'hF0000014, switch input (read-only)

Ports:
- clk  in  1  system clock, rising edge active
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- wrEn  in  1  store enable for the current instruction
- addr  in  DBITS  byte address (ALU output)
- wrData  in  DBITS  store data
- SW  in  10  board switches
- KEY  in  4  board keys, raw levels
- LEDR  out  10  red LEDs
- LEDG  out  8  green LEDs
- HEX0  out  7  digit 0, active-low segments {g,f,e,d,c,b,a}
- HEX1  out  7  digit 1, same encoding
- HEX2  out  7  digit 2, same encoding
- HEX3  out  7  digit 3, same encoding
- rdData  out  DBITS  load data

Behaviour:
- Address decode:
  - I/O match compares addr[31:2] exactly against each ADDR_* value's [31:2].
  - Any other address accesses RAM word addr[DMEMADDRBITS-1:DMEMWORDBITS], i.e. addr[12:2]. Upper bits are ignored, so RAM aliases every 8 KB.
  - addr[1:0] are always ignored; there are no byte or halfword accesses.
- Read path:
  - Fully combinational: rdData follows addr and stored state in the same cycle, with zero latency. This is required for single-cycle loads.
  - RAM address returns the stored word.
  - ADDR_HEX returns {16'b0, hexReg[15:0]}.
  - ADDR_LEDR returns {22'b0, ledrReg}.
  - ADDR_LEDG returns {24'b0, ledgReg}.
  - ADDR_KEY returns {28'b0, KEY}.
  - ADDR_SW returns {22'b0, SW}.
- Write path:
  - All writes occur on the rising clk edge when wrEn=1.
  - RAM target: word <= wrData.
  - ADDR_HEX: hexReg <= wrData[15:0].
  - ADDR_LEDR: ledrReg <= wrData[9:0].
  - ADDR_LEDG: ledgReg <= wrData[7:0].
  - Writes to ADDR_KEY or ADDR_SW are ignored and leave RAM unchanged.
- Timing:
  - A load in the cycle after a store to the same address returns the new value.
  - A read of the address being written in the same cycle returns the old value until the edge.
- Outputs:
  - LEDR = ledrReg and LEDG = ledgReg, driven directly.
  - HEXn = seg7(hexReg[4n+3:4n]).
  - seg7 map (active-low gfedcba):
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000
    - 4=0011001, 5=0010010, 6=0000010, 7=1111000
    - 8=0000000, 9=0010000, A=0001000, b=0000011
    - C=1000110, d=0100001, E=0000110, F=0001110
- Reset (reset=0, asynchronous):
  - hexReg=0, ledrReg=0, ledgReg=0, so HEX0..3 show "0" (1000000) and all LEDs are off.
  - RAM contents are not reset. Simulation initialises RAM to zero.
  - Writes are blocked while reset is asserted.
  - Reset asserted mid-store cancels that store's I/O register update.

Test Plan:
- Store 0x00000037 to 0x400, then 0x000000E1 to 0x404. Load 0x404 -> rdData=0x000000E1; load 0x400 (addr 0x404 + (-4)) -> 0x00000037.
- Store 0xDEADBEEF to 0x2400 -> load 0x400 returns 0xDEADBEEF (alias). Load 0x402 -> same word (low bits ignored).
- Store 0x1234 to 0xF0000000:
  - HEX0=0011001 (4), HEX1=0110000 (3), HEX2=0100100 (2), HEX3=1111001 (1).
  - Load 0xF0000000 -> 0x00001234.
- Store 0xFFFFFFFF to LEDR and to LEDG -> LEDR=0x3FF, LEDG=0xFF, and readback gives 0x3FF / 0xFF.
- SW=0x2A5, KEY=0xA:
  - Load 0xF0000014 -> 0x000002A5; load 0xF0000010 -> 0x0000000A.
  - Store to 0xF0000014 has no effect.
- Assert reset asynchronously between edges after the LED/HEX writes -> LEDR=0, LEDG=0, HEX0..3=1000000 immediately. RAM word 0x400 still reads 0x00000037.
